// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - Wishbone slave bus bundle for the instruction memory loader
interface imem_loader_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - Wishbone word-to-byte serializer feeding the instruction memory
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          ADDR_W    = 8
) (
   input  logic              clock,
   input  logic              reset,
   imem_loader_if.slave      wb,
   output logic [ADDR_W-1:0] instr_mem_addr,
   output logic [7:0]        instr_mem_data,
   output logic              instr_mem_en,
   output logic              cpu_hold,
   output logic              busy
);

   localparam logic [3:0] OFF_PTR    = 4'h0;
   localparam logic [3:0] OFF_DATA   = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;
   localparam logic [3:0] OFF_HOLD   = 4'hC;

   typedef enum logic [1:0] {IDLE, SHIFT, ACK} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] count;
   logic [31:0]       shreg;
   logic [3:0]        mask;
   logic [1:0]        lane;

   logic              req;
   logic [3:0]        off;
   logic [31:0]       status_word;
   logic [ADDR_W-1:0] ptr_step;
   logic [ADDR_W-1:0] count_step;

   // Request decode, status image and the pointer/counter values after the current lane.
   // mask[0] always describes the lane currently on the memory port.
   always_comb begin
      req         = wb.wbs_stb_i & wb.wbs_cyc_i & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
      off         = wb.wbs_adr_i[3:0];
      status_word = {8'h00, 8'(count), 8'(ptr), 7'h00, busy};
      ptr_step    = mask[0] ? ptr + ADDR_W'(1) : ptr;
      count_step  = (mask[0] && count != '1) ? count + ADDR_W'(1) : count;
   end

   // Control FSM: register accesses ack next cycle, DATA writes drain four lanes then ack.
   // Memory port outputs are loaded one cycle ahead so each lane appears on its own cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         wb.wbs_ack_o   <= 1'b0;
         wb.wbs_dat_o   <= 32'h0;
         instr_mem_en   <= 1'b0;
         instr_mem_addr <= '0;
         instr_mem_data <= 8'h00;
         ptr            <= '0;
         count          <= '0;
         cpu_hold       <= 1'b1;
         busy           <= 1'b0;
         shreg          <= 32'h0;
         mask           <= 4'h0;
         lane           <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (wb.wbs_we_i && off == OFF_DATA) begin
                     shreg          <= wb.wbs_dat_i;
                     mask           <= wb.wbs_sel_i;
                     lane           <= 2'd0;
                     busy           <= 1'b1;
                     instr_mem_en   <= wb.wbs_sel_i[0];
                     instr_mem_addr <= ptr;
                     instr_mem_data <= wb.wbs_dat_i[7:0];
                     state          <= SHIFT;
                  end else begin
                     wb.wbs_dat_o <= 32'h0;
                     if (wb.wbs_we_i) begin
                        case (off)
                           OFF_PTR: begin
                              ptr   <= wb.wbs_dat_i[ADDR_W-1:0];
                              count <= '0;
                           end
                           OFF_HOLD: cpu_hold <= wb.wbs_dat_i[0];
                           default: ;
                        endcase
                     end else begin
                        case (off)
                           OFF_PTR:    wb.wbs_dat_o <= 32'(ptr);
                           OFF_STATUS: wb.wbs_dat_o <= status_word;
                           OFF_HOLD:   wb.wbs_dat_o <= {31'h0, cpu_hold};
                           default:    wb.wbs_dat_o <= 32'h0;
                        endcase
                     end
                     wb.wbs_ack_o <= 1'b1;
                     state        <= ACK;
                  end
               end
            end
            SHIFT: begin
               ptr   <= ptr_step;
               count <= count_step;
               if (lane == 2'd3) begin
                  instr_mem_en <= 1'b0;
                  busy         <= 1'b0;
                  wb.wbs_dat_o <= 32'h0;
                  wb.wbs_ack_o <= 1'b1;
                  state        <= ACK;
               end else begin
                  lane           <= lane + 2'd1;
                  shreg          <= {8'h00, shreg[31:8]};
                  mask           <= {1'b0, mask[3:1]};
                  instr_mem_en   <= mask[1];
                  instr_mem_addr <= ptr_step;
                  instr_mem_data <= shreg[15:8];
               end
            end
            ACK: begin
               wb.wbs_ack_o <= 1'b0;
               wb.wbs_dat_o <= 32'h0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - Self-checking bench for imem_loader
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] instr_mem_addr;
   logic [7:0] instr_mem_data;
   logic       instr_mem_en;
   logic       cpu_hold;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] exp_q[$];

   imem_loader_if bus();

   imem_loader #(.BASE_ADDR(BASE), .ADDR_W(8)) dut (
      .clock          (clock),
      .reset          (reset),
      .wb             (bus.slave),
      .instr_mem_addr (instr_mem_addr),
      .instr_mem_data (instr_mem_data),
      .instr_mem_en   (instr_mem_en),
      .cpu_hold       (cpu_hold),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Memory-side scoreboard: every byte write must match the next expected (addr,data).
   always @(negedge clock) begin
      if (instr_mem_en === 1'b1) begin
         check("en_only_while_busy", 32'(busy), 32'h1);
         if (exp_q.size() == 0)
            check("mem_extra_write", {16'h0, instr_mem_addr, instr_mem_data}, 32'hFFFF_FFFF);
         else
            check("mem_write", {16'h0, instr_mem_addr, instr_mem_data}, {16'h0, exp_q.pop_front()});
      end
   end

   task automatic bus_idle();
      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 32'h0;
      bus.wbs_dat_i = 32'h0;
   endtask

   task automatic bus_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
      bus.wbs_stb_i = 1'b1;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
      bus.wbs_sel_i = sel;
   endtask

   // One bus transaction; latency counted in cycles after the request edge.
   task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int exp_lat, output logic [31:0] rdata);
      int lat;
      bit got;
      @(posedge clock); #1;
      bus_drive(we, adr, dat, sel);
      @(posedge clock);
      lat   = 0;
      got   = 0;
      rdata = 32'h0;
      while (!got && lat < 20) begin
         @(negedge clock);
         lat++;
         if (bus.wbs_ack_o === 1'b1) begin
            got   = 1;
            rdata = bus.wbs_dat_o;
         end else if (we && adr[3:0] == 4'h4) begin
            check("busy_during_drain", 32'(busy), 32'h1);
         end
      end
      check("ack_latency", 32'(lat), 32'(exp_lat));
      @(posedge clock); #1;
      bus_idle();
   endtask

   task automatic wr_data(input logic [31:0] dat, input logic [3:0] sel, input logic [7:0] start);
      logic [31:0] d;
      logic [7:0]  p;
      p = start;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) begin
            exp_q.push_back({p, dat[8*i +: 8]});
            p = p + 8'd1;
         end
      end
      wb_access(1'b1, BASE + 32'h4, dat, sel, 5, d);
   endtask

   initial begin
      logic [31:0] rd;
      bus_idle();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_cpu_hold", 32'(cpu_hold), 32'h1);
      check("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
      check("rst_en", 32'(instr_mem_en), 32'h0);
      check("rst_dat_o", bus.wbs_dat_o, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      reset = 1'b1;
      wb_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, 1, rd);
      check("rst_status", rd, 32'h0000_0000);

      // PTR + full-word DATA
      wb_access(1'b1, BASE + 32'h0, 32'h10, 4'hF, 1, rd);
      wr_data(32'hDDCC_BBAA, 4'hF, 8'h10);
      wb_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, 1, rd);
      check("status_after_word", rd, 32'h0004_1400);

      // pointer wrap with sparse lanes
      wb_access(1'b1, BASE + 32'h0, 32'hFE, 4'hF, 1, rd);
      wr_data(32'h4433_2211, 4'b0101, 8'hFE);
      wb_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, 1, rd);
      check("status_after_wrap", rd, 32'h0002_0000);
      wb_access(1'b0, BASE + 32'h0, 32'h0, 4'hF, 1, rd);
      check("ptr_read_wrap", rd, 32'h0000_0000);

      // empty lane mask still takes the full drain time
      wr_data(32'hFFFF_FFFF, 4'b0000, 8'h00);

      // strobe held across two DATA writes: second only sampled after the first ack
      exp_q.push_back({8'h00, 8'hAA});
      exp_q.push_back({8'h01, 8'hBB});
      exp_q.push_back({8'h02, 8'hAA});
      exp_q.push_back({8'h03, 8'hBB});
      @(posedge clock); #1;
      bus_drive(1'b1, BASE + 32'h4, 32'h0000_BBAA, 4'b0011);
      @(posedge clock);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clock);
         check($sformatf("b2b_busy_c%0d", c), 32'(busy),
               32'(((c >= 1 && c <= 4) || (c >= 7 && c <= 10)) ? 1 : 0));
         check($sformatf("b2b_ack_c%0d", c), 32'(bus.wbs_ack_o),
               32'((c == 5 || c == 11) ? 1 : 0));
      end
      @(posedge clock); #1;
      bus_idle();
      wb_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, 1, rd);
      check("status_after_b2b", rd, 32'h0006_0400);

      // out-of-window access is never acknowledged and has no effect
      @(posedge clock); #1;
      bus_drive(1'b1, BASE + 32'h20, 32'h55, 4'hF);
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         check("nomatch_no_ack", 32'(bus.wbs_ack_o), 32'h0);
      end
      @(posedge clock); #1;
      bus_idle();
      wb_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, 1, rd);
      check("status_after_nomatch", rd, 32'h0006_0400);

      // HOLD release
      wb_access(1'b1, BASE + 32'hC, 32'h0, 4'hF, 1, rd);
      check("hold_cleared", 32'(cpu_hold), 32'h0);
      wb_access(1'b0, BASE + 32'hC, 32'h0, 4'hF, 1, rd);
      check("hold_read", rd, 32'h0000_0000);
      wb_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1, rd);
      check("data_read_zero", rd, 32'h0000_0000);

      // reset while lane 1 is on the memory port
      wb_access(1'b1, BASE + 32'h0, 32'h30, 4'hF, 1, rd);
      exp_q.push_back({8'h30, 8'h11});
      exp_q.push_back({8'h31, 8'h22});
      @(posedge clock); #1;
      bus_drive(1'b1, BASE + 32'h4, 32'h4433_2211, 4'hF);
      @(posedge clock);
      @(negedge clock);
      @(negedge clock);
      #1 reset = 1'b0;
      #1;
      check("midrst_en", 32'(instr_mem_en), 32'h0);
      check("midrst_ack", 32'(bus.wbs_ack_o), 32'h0);
      check("midrst_hold", 32'(cpu_hold), 32'h1);
      check("midrst_busy", 32'(busy), 32'h0);
      bus_idle();
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check("midrst_no_ack", 32'(bus.wbs_ack_o), 32'h0);
      end
      reset = 1'b1;
      wb_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, 1, rd);
      check("midrst_status", rd, 32'h0000_0000);

      repeat (2) @(negedge clock);
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
